// File: rtl/pesticide_dosing_ctrl.sv
// -----------------------------------------------------------------------------
// pesticide_dosing_ctrl
//
// Multi-tank pesticide dosing controller. Each tank has an active-low push
// button that requests one timed dose. A dose may only start while the shared
// process state is "pesticide window" (2'b01) and the tank still has dose
// quota left. The cleaning state (2'b10) re-arms every tank.
//
// Ports:
//   clk       in   system clock, all logic on the rising edge
//   init      in   synchronous active-high reset, overrides every other input
//   state     in   [1:0] process state: 00 idle, 01 window, 10 cleaning, 11 drain
//   button    in   [N_CH-1:0] raw tank buttons, active-low, asynchronous
//   valve_on  out  [N_CH-1:0] dosing valve, high while a dose runs
//   alert_on  out  [N_CH-1:0] green LED: tank dosing or quota exhausted
//   alert_np  out  [N_CH-1:0] red/yellow LED: button held while dosing impossible
//   dose_cnt  out  [N_CH*DW-1:0] per-tank dose counts, tank i at [i*DW +: DW]
// -----------------------------------------------------------------------------
module pesticide_dosing_ctrl #(
    parameter int N_CH        = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int DOSE_CYCLES = 8,
    parameter int MAX_DOSES   = 1,
    localparam int DW         = $clog2(MAX_DOSES + 1)
) (
    input  logic              clk,
    input  logic              init,
    input  logic [1:0]        state,
    input  logic [N_CH-1:0]   button,
    output logic [N_CH-1:0]   valve_on,
    output logic [N_CH-1:0]   alert_on,
    output logic [N_CH-1:0]   alert_np,
    output logic [N_CH*DW-1:0] dose_cnt
);

    // Counter widths. DEB_CYCLES and DOSE_CYCLES are >= 1.
    localparam int DBW = $clog2(DEB_CYCLES + 1);
    localparam int TW  = (DOSE_CYCLES > 1) ? $clog2(DOSE_CYCLES) : 1;

    localparam logic [DBW-1:0] DEB_LAST  = DBW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0]  DOSE_LAST = TW'(DOSE_CYCLES - 1);
    localparam logic [DW-1:0]  DOSE_MAX  = DW'(MAX_DOSES);

    // Process states
    localparam logic [1:0] PS_WINDOW = 2'b01;
    localparam logic [1:0] PS_CLEAN  = 2'b10;

    // Per-tank FSM states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DOSING = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic            sync1_reg;
            logic            sync2_reg;
            logic            deb_level_reg;     // 1 = released, 0 = pressed
            logic [DBW-1:0]  deb_cnt_reg;
            logic            press_pulse_reg;
            logic [1:0]      fsm_reg, fsm_next;
            logic [TW-1:0]   timer_reg, timer_next;
            logic [DW-1:0]   cnt_reg, cnt_next;
            logic            np_reg, np_next;
            logic            quota_full;

            // -----------------------------------------------------------------
            // Input path: 2-FF synchroniser, then a debouncer that only accepts
            // a new level after DEB_CYCLES consecutive differing samples.
            // press_pulse_reg is high for the cycle following the edge where
            // the debounced level becomes "pressed".
            // -----------------------------------------------------------------
            always_ff @(posedge clk) begin
                if (init) begin
                    sync1_reg       <= 1'b1;
                    sync2_reg       <= 1'b1;
                    deb_level_reg   <= 1'b1;
                    deb_cnt_reg     <= '0;
                    press_pulse_reg <= 1'b0;
                end else begin
                    sync1_reg       <= button[gi];
                    sync2_reg       <= sync1_reg;
                    press_pulse_reg <= 1'b0;
                    if (sync2_reg == deb_level_reg) begin
                        deb_cnt_reg <= '0;
                    end else if (deb_cnt_reg == DEB_LAST) begin
                        deb_cnt_reg     <= '0;
                        deb_level_reg   <= sync2_reg;
                        press_pulse_reg <= ~sync2_reg;
                    end else begin
                        deb_cnt_reg <= deb_cnt_reg + DBW'(1);
                    end
                end
            end

            assign quota_full = (cnt_reg == DOSE_MAX);

            // -----------------------------------------------------------------
            // Dose FSM. Cleaning wins over everything (and swallows a press
            // pulse arriving in the same cycle). Leaving the window mid-dose
            // aborts without counting the dose.
            // -----------------------------------------------------------------
            always_comb begin
                fsm_next   = fsm_reg;
                timer_next = timer_reg;
                cnt_next   = cnt_reg;
                if (state == PS_CLEAN) begin
                    fsm_next   = ST_IDLE;
                    timer_next = '0;
                    cnt_next   = '0;
                end else begin
                    case (fsm_reg)
                        ST_IDLE: begin
                            if (press_pulse_reg && (state == PS_WINDOW) && !quota_full) begin
                                fsm_next   = ST_DOSING;
                                timer_next = DOSE_LAST;
                            end
                        end
                        ST_DOSING: begin
                            if (state != PS_WINDOW) begin
                                fsm_next = ST_IDLE;
                            end else if (timer_reg == '0) begin
                                // Saturating: the count can never pass MAX_DOSES.
                                cnt_next = quota_full ? cnt_reg : cnt_reg + DW'(1);
                                fsm_next = (cnt_next == DOSE_MAX) ? ST_LOCKED : ST_IDLE;
                            end else begin
                                timer_next = timer_reg - TW'(1);
                            end
                        end
                        ST_LOCKED: begin
                            fsm_next = ST_LOCKED;
                        end
                        default: begin
                            fsm_next = ST_IDLE;
                        end
                    endcase
                end
            end

            // Held button while a dose cannot start: wrong process state, tank
            // busy, or quota used up. Evaluated on current registered values.
            always_comb begin
                np_next = ~deb_level_reg &&
                          ((state != PS_WINDOW) || (fsm_reg != ST_IDLE) || quota_full);
            end

            always_ff @(posedge clk) begin
                if (init) begin
                    fsm_reg   <= ST_IDLE;
                    timer_reg <= '0;
                    cnt_reg   <= '0;
                    np_reg    <= 1'b0;
                end else begin
                    fsm_reg   <= fsm_next;
                    timer_reg <= timer_next;
                    cnt_reg   <= cnt_next;
                    np_reg    <= np_next;
                end
            end

            assign valve_on[gi]           = (fsm_reg == ST_DOSING);
            assign alert_on[gi]           = (fsm_reg == ST_DOSING) || (fsm_reg == ST_LOCKED);
            assign alert_np[gi]           = np_reg;
            assign dose_cnt[gi*DW +: DW]  = cnt_reg;
        end
    endgenerate

endmodule

// File: tb/tb_pesticide_dosing_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pesticide_dosing_ctrl
//
// Two controller instances share clock, init, state and buttons:
//   dut_a : MAX_DOSES = 1 (single dose per cleaning cycle)
//   dut_b : MAX_DOSES = 2 (abort / multi-dose / clear scenarios)
// Each stimulus step pushes the expected output values, tagged with the cycle
// they must appear in, onto a scoreboard queue. A monitor on the falling edge
// pops every entry due in the current cycle and compares it with the DUT.
// Cycle n means "outputs after rising edge n".
// -----------------------------------------------------------------------------
module tb_pesticide_dosing_ctrl;

    localparam int N_CH = 2;
    localparam int DW_A = 1;
    localparam int DW_B = 2;

    localparam int SIG_VALVE = 0;
    localparam int SIG_ON    = 1;
    localparam int SIG_NP    = 2;
    localparam int SIG_CNT   = 3;

    logic                   clk = 1'b0;
    logic                   init;
    logic [1:0]             state;
    logic [N_CH-1:0]        button;
    logic [N_CH-1:0]        valve_a, on_a, np_a;
    logic [N_CH-1:0]        valve_b, on_b, np_b;
    logic [N_CH*DW_A-1:0]   cnt_a;
    logic [N_CH*DW_B-1:0]   cnt_b;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int    cyc;
        int    dut;
        int    sig;
        int    ch;      // -1 = whole bus
        int    val;
        string tag;
    } exp_t;

    exp_t sb_q[$];

    pesticide_dosing_ctrl #(
        .N_CH(N_CH), .DEB_CYCLES(4), .DOSE_CYCLES(8), .MAX_DOSES(1)
    ) dut_a (
        .clk(clk), .init(init), .state(state), .button(button),
        .valve_on(valve_a), .alert_on(on_a), .alert_np(np_a), .dose_cnt(cnt_a)
    );

    pesticide_dosing_ctrl #(
        .N_CH(N_CH), .DEB_CYCLES(4), .DOSE_CYCLES(8), .MAX_DOSES(2)
    ) dut_b (
        .clk(clk), .init(init), .state(state), .button(button),
        .valve_on(valve_b), .alert_on(on_b), .alert_np(np_b), .dose_cnt(cnt_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", tag, actual, expected);
        end
    endtask

    function automatic int get_sig(input int d, input int s, input int ch);
        logic [N_CH-1:0]      v;
        logic [N_CH*DW_B-1:0] c;
        int                   w;
        w = (d == 0) ? DW_A : DW_B;
        c = '0;
        if (d == 0) c[N_CH*DW_A-1:0] = cnt_a;
        else        c = cnt_b;
        case (s)
            SIG_VALVE: v = (d == 0) ? valve_a : valve_b;
            SIG_ON:    v = (d == 0) ? on_a    : on_b;
            SIG_NP:    v = (d == 0) ? np_a    : np_b;
            default:   v = '0;
        endcase
        if (s == SIG_CNT) begin
            if (ch < 0) return int'(c);
            return int'((c >> (ch * w)) & ((1 << w) - 1));
        end
        if (ch < 0) return int'(v);
        return int'(v[ch]);
    endfunction

    // Monitor: compare every entry due now; anything overdue is reported too.
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc <= cyc) begin
                check($sformatf("%s dut%0d sig%0d ch%0d cyc%0d", sb_q[i].tag, sb_q[i].dut,
                                sb_q[i].sig, sb_q[i].ch, sb_q[i].cyc),
                      (sb_q[i].cyc == cyc) ? get_sig(sb_q[i].dut, sb_q[i].sig, sb_q[i].ch) : -1,
                      sb_q[i].val);
                sb_q.delete(i);
            end
        end
    end

    task automatic exp_range(input int d, input int s, input int ch, input int from,
                             input int to, input int val, input string tag);
        for (int c = from; c <= to; c++) begin
            exp_t e;
            e.cyc = c; e.dut = d; e.sig = s; e.ch = ch; e.val = val; e.tag = tag;
            sb_q.push_back(e);
        end
    endtask

    // Advance n rising edges; inputs change 2 time units after the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Expected valve / count timeline of one full dose whose first sampled
    // low is edge k: valve high for edges k+6..k+13, count bumps at k+14.
    task automatic exp_full_dose(input int d, input int ch, input int k,
                                 input int cnt_before, input int cnt_after, input string tag);
        exp_range(d, SIG_VALVE, ch, k + 5,  k + 5,  0, tag);
        exp_range(d, SIG_VALVE, ch, k + 6,  k + 13, 1, tag);
        exp_range(d, SIG_VALVE, ch, k + 14, k + 16, 0, tag);
        exp_range(d, SIG_CNT,   ch, k + 13, k + 13, cnt_before, tag);
        exp_range(d, SIG_CNT,   ch, k + 14, k + 16, cnt_after, tag);
    endtask

    initial begin
        int k;
        int c;
        init   = 1'b1;
        state  = 2'b01;
        button = 2'b11;

        // ---------------- reset / idle ----------------
        step(2);
        $display("txn reset: init held 2 cycles, state=01, buttons released (cycle %0d)", cyc);
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < 4; s++)
                exp_range(d, s, -1, cyc, cyc + 20, 0, "reset");
        init = 1'b0;
        step(20);

        // ---------------- single dose, MAX=1 ----------------
        k = cyc + 1;
        $display("txn dose: ch0 pressed 10 cycles in window (first sample edge %0d)", k);
        button[0] = 1'b0;
        exp_full_dose(0, 0, k, 0, 1, "dose1");
        exp_range(0, SIG_CNT, 0, k + 17, k + 30, 1, "dose1_cnt_hold");
        exp_range(0, SIG_ON,  0, k + 5,  k + 5,  0, "dose1_on");
        exp_range(0, SIG_ON,  0, k + 6,  k + 40, 1, "dose1_on");
        exp_range(0, SIG_NP,  0, k + 6,  k + 6,  0, "dose1_np");
        exp_range(0, SIG_NP,  0, k + 7,  k + 15, 1, "dose1_np");
        exp_range(0, SIG_NP,  0, k + 16, k + 16, 0, "dose1_np");
        step(10);
        button[0] = 1'b1;
        step(20);

        k = cyc + 1;
        $display("txn locked: ch0 pressed again with quota used (first sample edge %0d)", k);
        button[0] = 1'b0;
        exp_range(0, SIG_VALVE, 0, k,      k + 20, 0, "locked_valve");
        exp_range(0, SIG_CNT,   0, k,      k + 20, 1, "locked_cnt");
        exp_range(0, SIG_NP,    0, k + 5,  k + 5,  0, "locked_np");
        exp_range(0, SIG_NP,    0, k + 6,  k + 15, 1, "locked_np");
        exp_range(0, SIG_NP,    0, k + 16, k + 16, 0, "locked_np");
        step(10);
        button[0] = 1'b1;
        step(20);

        // ---------------- bounce rejection on ch1 ----------------
        k = cyc + 1;
        $display("txn bounce: ch1 low 3 / high 1 x5 (first sample edge %0d)", k);
        for (int s = 0; s < 4; s++)
            exp_range(0, s, 1, k, k + 25, 0, "bounce");
        exp_range(0, SIG_CNT, 0, k, k + 25, 1, "bounce_ch0_cnt");
        repeat (5) begin
            button[1] = 1'b0;
            step(3);
            button[1] = 1'b1;
            step(1);
        end
        step(10);

        // ---------------- clear, then wrong-state press ----------------
        c = cyc;
        $display("txn clear: state=10 for one cycle (edge %0d)", c + 1);
        exp_range(0, SIG_CNT, 0, c, c, 1, "pre_clear_cnt");
        for (int d = 0; d < 2; d++) begin
            exp_range(d, SIG_CNT, -1, c + 1, c + 1, 0, "clear_cnt");
            exp_range(d, SIG_ON,  -1, c + 1, c + 1, 0, "clear_on");
        end
        state = 2'b10;
        step(1);
        state = 2'b00;
        step(2);

        k = cyc + 1;
        $display("txn wrong_state: ch0 pressed 8 cycles with state=00 (first sample edge %0d)", k);
        button[0] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            exp_range(d, SIG_VALVE, 0, k,      k + 20, 0, "wrong_valve");
            exp_range(d, SIG_ON,    0, k,      k + 20, 0, "wrong_on");
            exp_range(d, SIG_NP,    0, k + 5,  k + 5,  0, "wrong_np");
            exp_range(d, SIG_NP,    0, k + 6,  k + 13, 1, "wrong_np");
            exp_range(d, SIG_NP,    0, k + 14, k + 14, 0, "wrong_np");
        end
        step(8);
        button[0] = 1'b1;
        step(20);

        // ---------------- abort, two doses, clear (MAX=2) ----------------
        state = 2'b01;
        step(2);
        k = cyc + 1;
        $display("txn abort: ch0 dose, state=11 in dose cycle 3 (first sample edge %0d)", k);
        button[0] = 1'b0;
        exp_range(1, SIG_VALVE, 0, k + 5, k + 5,  0, "abort_valve");
        exp_range(1, SIG_VALVE, 0, k + 6, k + 8,  1, "abort_valve");
        exp_range(1, SIG_VALVE, 0, k + 9, k + 20, 0, "abort_valve");
        exp_range(1, SIG_ON,    0, k + 6, k + 8,  1, "abort_on");
        exp_range(1, SIG_ON,    0, k + 9, k + 9,  0, "abort_on");
        exp_range(1, SIG_CNT,   0, k,     k + 20, 0, "abort_cnt");
        step(9);
        state = 2'b11;
        step(1);
        button[0] = 1'b1;
        state     = 2'b01;
        step(20);

        k = cyc + 1;
        $display("txn dose_b1: ch0 first dose of two (first sample edge %0d)", k);
        button[0] = 1'b0;
        exp_full_dose(1, 0, k, 0, 1, "b_dose1");
        exp_range(1, SIG_ON, 0, k + 14, k + 18, 0, "b_dose1_on");
        step(10);
        button[0] = 1'b1;
        step(15);

        k = cyc + 1;
        $display("txn dose_b2: ch0 second dose of two (first sample edge %0d)", k);
        button[0] = 1'b0;
        exp_full_dose(1, 0, k, 1, 2, "b_dose2");
        exp_range(1, SIG_CNT, 0, k + 17, k + 20, 2, "b_dose2_sat");
        exp_range(1, SIG_ON,  0, k + 14, k + 20, 1, "b_dose2_on");
        step(10);
        button[0] = 1'b1;
        step(15);

        c = cyc;
        $display("txn clear_b: state=10 for one cycle (edge %0d)", c + 1);
        exp_range(1, SIG_CNT, 0, c,     c,     2, "b_pre_clear_cnt");
        exp_range(1, SIG_ON,  0, c,     c,     1, "b_pre_clear_on");
        exp_range(1, SIG_CNT, 0, c + 1, c + 1, 0, "b_clear_cnt");
        exp_range(1, SIG_ON,  0, c + 1, c + 1, 0, "b_clear_on");
        state = 2'b10;
        step(1);
        state = 2'b01;
        step(2);

        k = cyc + 1;
        $display("txn dose_b3: ch0 dose after clear (first sample edge %0d)", k);
        button[0] = 1'b0;
        exp_full_dose(1, 0, k, 0, 1, "b_dose3");
        step(10);
        button[0] = 1'b1;
        step(15);

        // ---------------- concurrency and init mid-dose ----------------
        state = 2'b10;
        step(1);
        state = 2'b01;
        step(2);
        k = cyc + 1;
        $display("txn concurrent: ch0+ch1 pressed together, init in dose cycle 5 (first sample edge %0d)", k);
        button = 2'b00;
        for (int d = 0; d < 2; d++) begin
            exp_range(d, SIG_VALVE, -1, k + 5, k + 5,  0, "conc_valve");
            exp_range(d, SIG_VALVE, -1, k + 6, k + 10, 3, "conc_valve");
            exp_range(d, SIG_NP,    -1, k + 8, k + 10, 3, "conc_np_held");
        end
        step(11);
        init = 1'b1;
        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < 4; s++)
                exp_range(d, s, -1, k + 11, k + 11, 0, "init_mid_dose");
            exp_range(d, SIG_VALVE, -1, k + 12, k + 17, 0, "post_init_deb");
            exp_range(d, SIG_VALVE, -1, k + 18, k + 20, 3, "post_init_dose");
        end
        step(1);
        init = 1'b0;
        step(10);
        button = 2'b11;
        step(20);

        check("sb_left", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

endmodule
